// File: rtl/fp_cmp_share_arbiter.sv
// fp_cmp_share_arbiter: round-robin sharing of one pipelined FloPoCo sp comparator among N_REQ clients
// Define FP_CMP_ARB_PERF_EN to add saturating issue/stall performance counters.
module fp_cmp_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int CMP_STAGES = 2,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*34-1:0]  req_x,
  input  logic [N_REQ*34-1:0]  req_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_lt,
  output logic                 rsp_eq,
  output logic                 rsp_le,
  output logic                 rsp_unordered,
  output logic                 cmp_ce,
  output logic [33:0]          cmp_x,
  output logic [33:0]          cmp_y,
  input  logic                 cmp_lt,
  input  logic                 cmp_eq,
  input  logic                 cmp_le,
  input  logic                 cmp_unordered
`ifdef FP_CMP_ARB_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);
  logic [CMP_STAGES:1] vld;
  logic [ID_W-1:0]     id_q [1:CMP_STAGES];
  logic [ID_W-1:0]     rr_ptr, grant, idx;
  logic                found, stall, fire;
  assign stall  = vld[CMP_STAGES] & ~rsp_ready;
  assign cmp_ce = ~stall;
  // Scan from the highest offset down so the nearest requester at/after rr_ptr wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
  assign fire      = found & ~stall & rst_n;
  assign req_ready = fire ? N_REQ'(1) << grant : '0;
  assign cmp_x     = fire ? req_x[34*grant +: 34] : '0;
  assign cmp_y     = fire ? req_y[34*grant +: 34] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      rr_ptr <= '0;
      for (int s = 1; s <= CMP_STAGES; s++) id_q[s] <= '0;
    end else if (cmp_ce) begin
      vld[1]  <= fire;
      id_q[1] <= grant;
      for (int s = 2; s <= CMP_STAGES; s++) begin
        vld[s]  <= vld[s-1];
        id_q[s] <= id_q[s-1];
      end
      if (fire) rr_ptr <= grant == ID_W'(N_REQ - 1) ? '0 : grant + 1'b1;
    end
  end
  assign rsp_valid     = vld[CMP_STAGES];
  assign rsp_id        = id_q[CMP_STAGES];
  assign rsp_lt        = cmp_lt;
  assign rsp_eq        = cmp_eq;
  assign rsp_le        = cmp_le;
  assign rsp_unordered = cmp_unordered;
`ifdef FP_CMP_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fire && !(&perf_issue_cnt)) perf_issue_cnt <= perf_issue_cnt + 1'b1;
      if (stall && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fp_cmp_share_arbiter.sv
// tb_fp_cmp_share_arbiter: directed bench with a behavioural 2-stage FloPoCo comparator attached
module tb_fp_cmp_share_arbiter;
  localparam int N = 4;
  localparam logic [33:0] ONE   = {2'b01, 1'b0, 8'h7f, 23'h0};
  localparam logic [33:0] TWO   = {2'b01, 1'b0, 8'h80, 23'h0};
  localparam logic [33:0] MONE  = {2'b01, 1'b1, 8'h7f, 23'h0};
  localparam logic [33:0] QNAN  = {2'b11, 32'h0};
  localparam logic [33:0] PZERO = 34'h0;
  localparam logic [33:0] NZERO = {2'b00, 1'b1, 31'h0};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic           rst_n, rsp_ready, rsp_valid, cmp_ce;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*34-1:0] req_x, req_y;
  logic [1:0]     rsp_id;
  logic           rsp_lt, rsp_eq, rsp_le, rsp_unordered;
  logic [33:0]    cmp_x, cmp_y;
  logic           cmp_lt, cmp_eq, cmp_le, cmp_unordered;
`ifdef FP_CMP_ARB_PERF_EN
  logic [31:0]    perf_issue_cnt, perf_stall_cnt;
`endif
  fp_cmp_share_arbiter #(.N_REQ(N), .CMP_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_le(rsp_le), .rsp_unordered(rsp_unordered),
    .cmp_ce(cmp_ce), .cmp_x(cmp_x), .cmp_y(cmp_y),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_le(cmp_le), .cmp_unordered(cmp_unordered)
`ifdef FP_CMP_ARB_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );
  // Ordering key: zeros collapse to 0, then exception class, exponent, fraction; sign negates.
  function automatic logic signed [35:0] key(input logic [33:0] a);
    logic signed [35:0] m;
    m = (a[33:32] == 2'b00) ? 36'sd0 : {3'b000, a[33:32], a[30:0]};
    return a[31] ? -m : m;
  endfunction
  function automatic logic [3:0] fcmp(input logic [33:0] a, input logic [33:0] b);
    logic signed [35:0] va, vb;
    if (a[33:32] == 2'b11 || b[33:32] == 2'b11) return 4'b0001;
    va = key(a);
    vb = key(b);
    return {va < vb, va == vb, va <= vb, 1'b0};
  endfunction
  logic [3:0] cp1, cp2;
  always @(posedge clk) if (cmp_ce) begin
    cp1 <= fcmp(cmp_x, cmp_y);
    cp2 <= cp1;
  end
  assign {cmp_lt, cmp_eq, cmp_le, cmp_unordered} = cp2;
  wire [3:0] flags = {rsp_lt, rsp_eq, rsp_le, rsp_unordered};
  int total = 0;
  int bad = 0;
  logic [3:0] exp_fl [4];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic set_req(input int i, input logic [33:0] x, input logic [33:0] y);
    req_x[34*i +: 34] = x;
    req_y[34*i +: 34] = y;
  endtask
  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '1; req_x = '0; req_y = '0;
    set_req(0, ONE, TWO);
    set_req(1, TWO, ONE);
    set_req(2, ONE, ONE);
    set_req(3, MONE, ONE);
    exp_fl[0] = 4'b1010; exp_fl[1] = 4'b0000; exp_fl[2] = 4'b0110; exp_fl[3] = 4'b1010;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_ce", cmp_ce, 1);
    chk("rst_cmpx", cmp_x, 0);
    chk("rst_cmpy", cmp_y, 0);
    chk("rst_id", rsp_id, 0);
    req_valid = '0;
    cyc(); rst_n = 1'b1;
    cyc(); #1;
    chk("idle_ready", req_ready, 0);
    // single compare 1.0 vs 2.0 from requester 0
    cyc(); req_valid = 4'b0001; #1;
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_cmpx", cmp_x, ONE);
    chk("t1_cmpy", cmp_y, TWO);
    chk("t1_rv0", rsp_valid, 0);
    cyc(); req_valid = '0; #1;
    chk("t1_rv1", rsp_valid, 0);
    cyc(); #1;
    chk("t1_rv", rsp_valid, 1);
    chk("t1_id", rsp_id, 0);
    chk("t1_fl", flags, 4'b1010);
    cyc(); #1;
    chk("t1_done", rsp_valid, 0);
    // continuous requests from all, rr_ptr starts at 1
    for (int k = 0; k < 8; k++) begin
      cyc(); req_valid = (k < 6) ? '1 : '0; #1;
      chk("t2_ready", req_ready, (k < 6) ? (64'd1 << ((1 + k) % 4)) : 64'd0);
      chk("t2_rv", rsp_valid, (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        chk("t2_id", rsp_id, (k - 1) % 4);
        chk("t2_fl", flags, exp_fl[(k - 1) % 4]);
      end
    end
    cyc(); #1;
    chk("t2_done", rsp_valid, 0);
    // stream with 3-cycle back-pressure, rr_ptr = 3
    cyc(); req_valid = '1; #1;
    chk("t3_ready0", req_ready, 4'b1000);
    cyc(); #1;
    chk("t3_ready1", req_ready, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      cyc(); rsp_ready = 1'b0; #1;
      chk("t3_ce", cmp_ce, 0);
      chk("t3_ready_st", req_ready, 0);
      chk("t3_rv_st", rsp_valid, 1);
      chk("t3_id_st", rsp_id, 3);
      chk("t3_fl_st", flags, 4'b1010);
    end
    cyc(); rsp_ready = 1'b1; #1;
    chk("t3_ce_rel", cmp_ce, 1);
    chk("t3_ready5", req_ready, 4'b0010);
    chk("t3_id5", rsp_id, 3);
    cyc(); #1;
    chk("t3_ready6", req_ready, 4'b0100);
    chk("t3_id6", rsp_id, 0);
    chk("t3_fl6", flags, 4'b1010);
    cyc(); req_valid = '0; #1;
    chk("t3_rv7", rsp_valid, 1);
    chk("t3_id7", rsp_id, 1);
    chk("t3_fl7", flags, 4'b0000);
    cyc(); #1;
    chk("t3_id8", rsp_id, 2);
    chk("t3_fl8", flags, 4'b0110);
    cyc(); #1;
    chk("t3_done", rsp_valid, 0);
`ifdef FP_CMP_ARB_PERF_EN
    chk("perf_issue", perf_issue_cnt, 11);
    chk("perf_stall", perf_stall_cnt, 3);
`endif
    // NaN and signed zeros from requester 2, wrapping from rr_ptr = 3
    cyc(); set_req(2, QNAN, ONE); req_valid = 4'b0100; #1;
    chk("t4_ready0", req_ready, 4'b0100);
    cyc(); set_req(2, NZERO, PZERO); #1;
    chk("t4_ready1", req_ready, 4'b0100);
    cyc(); req_valid = '0; #1;
    chk("t4_rv_nan", rsp_valid, 1);
    chk("t4_id_nan", rsp_id, 2);
    chk("t4_fl_nan", flags, 4'b0001);
    cyc(); #1;
    chk("t4_id_z", rsp_id, 2);
    chk("t4_fl_z", flags, 4'b0110);
    cyc(); #1;
    chk("t4_done", rsp_valid, 0);
    // reset with two compares in flight
    cyc(); req_valid = '1; #1;
    chk("t5_ready0", req_ready, 4'b1000);
    cyc(); #1;
    chk("t5_ready1", req_ready, 4'b0001);
    cyc(); #1;
    chk("t5_pre_rv", rsp_valid, 1);
    req_valid = '0; rst_n = 1'b0; #1;
    chk("t5_rst_rv", rsp_valid, 0);
    chk("t5_rst_id", rsp_id, 0);
    chk("t5_rst_ce", cmp_ce, 1);
    cyc(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk("t5_nostale", rsp_valid, 0);
    end
    cyc(); req_valid = '1; #1;
    chk("t5_rr0", req_ready, 4'b0001);
`ifdef FP_CMP_ARB_PERF_EN
    chk("perf_rst_issue", perf_issue_cnt, 0);
    chk("perf_rst_stall", perf_stall_cnt, 0);
`endif
    cyc(); req_valid = '0; #1;
`ifdef FP_CMP_ARB_PERF_EN
    chk("perf_issue1", perf_issue_cnt, 1);
`endif
    cyc(); #1;
    chk("t5_rv", rsp_valid, 1);
    chk("t5_id", rsp_id, 0);
    chk("t5_fl", flags, 4'b1010);
    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
